pe_id_cfg_loader: RTL

Sequencer that loads the multicast-controller IDs of the 6x8 PE array at the start of each layer. Consumes the X/Y ID vectors from `pe_array_id_generator` for the filter, ifmap, ipsum and opsum networks. Streams them one entry per handshake over a single config bus into the GLB-to-PE and PE-to-GLB buses. Sits between the layer controller, which pulses `start`, and the PE array config port.

---
 rtl/pe_id_cfg_loader.sv | 226 ++++++++++++++++++++++
 1 files changed

// File: rtl/pe_id_cfg_loader.sv
// Streams the multicast-controller X/Y IDs of the PE array over one config bus.
// Per network: Y IDs for each row, then X IDs in row-major order.
module pe_id_cfg_loader #(
    parameter int NUM_ROW     = 6,
    parameter int NUM_COL     = 8,
    parameter int XID_W       = 5,
    parameter int YID_W       = 3,
    parameter bit SKIP_UNUSED = 1'b1
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             start,
    input  logic [NUM_ROW*NUM_COL*XID_W-1:0] filter_xid,
    input  logic [NUM_ROW*NUM_COL*XID_W-1:0] ifmap_xid,
    input  logic [NUM_ROW*NUM_COL*XID_W-1:0] ipsum_xid,
    input  logic [NUM_ROW*NUM_COL*XID_W-1:0] opsum_xid,
    input  logic [NUM_ROW*YID_W-1:0]         filter_yid,
    input  logic [NUM_ROW*YID_W-1:0]         ifmap_yid,
    input  logic [NUM_ROW*YID_W-1:0]         ipsum_yid,
    input  logic [NUM_ROW*YID_W-1:0]         opsum_yid,
    output logic                             cfg_valid,
    input  logic                             cfg_ready,
    output logic [1:0]                       cfg_net,
    output logic                             cfg_is_y,
    output logic [2:0]                       cfg_row,
    output logic [3:0]                       cfg_col,
    output logic [XID_W-1:0]                 cfg_id,
    output logic                             busy,
    output logic                             done
);

    localparam int NUM_PE = NUM_ROW * NUM_COL;
    localparam int IDX_W  = $clog2(NUM_PE);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_SEND = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [XID_W-1:0] X_UNUSED = '1;
    localparam logic [YID_W-1:0] Y_UNUSED = '1;

    logic [1:0]       state_q, state_d;
    logic [1:0]       net_q, net_d;
    logic             is_y_q, is_y_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             end_q, end_d;
    logic             valid_q, valid_d;
    logic [1:0]       o_net_q, o_net_d;
    logic             o_is_y_q, o_is_y_d;
    logic [2:0]       o_row_q, o_row_d;
    logic [3:0]       o_col_q, o_col_d;
    logic [XID_W-1:0] o_id_q, o_id_d;

    logic [NUM_PE*XID_W-1:0]  x_bus;
    logic [NUM_ROW*YID_W-1:0] y_bus;
    logic [XID_W-1:0]         sel_x;
    logic [YID_W-1:0]         sel_y;
    logic [XID_W-1:0]         cur_id;
    logic [2:0]               cur_row;
    logic [3:0]               cur_col;
    logic                     cur_skip;

    logic [1:0]       nxt_net;
    logic             nxt_is_y;
    logic [IDX_W-1:0] nxt_idx;
    logic             nxt_end;

    always_comb begin
        x_bus = filter_xid;
        y_bus = filter_yid;
        unique case (net_q)
            2'd0: begin
                x_bus = filter_xid;
                y_bus = filter_yid;
            end
            2'd1: begin
                x_bus = ifmap_xid;
                y_bus = ifmap_yid;
            end
            2'd2: begin
                x_bus = ipsum_xid;
                y_bus = ipsum_yid;
            end
            2'd3: begin
                x_bus = opsum_xid;
                y_bus = opsum_yid;
            end
        endcase
    end

    // Constant-index muxes keep every part-select in range.
    always_comb begin
        sel_x = '0;
        for (int k = 0; k < NUM_PE; k++) begin
            if (idx_q == IDX_W'(k)) sel_x = x_bus[k*XID_W +: XID_W];
        end
        sel_y = '0;
        for (int r = 0; r < NUM_ROW; r++) begin
            if (idx_q == IDX_W'(r)) sel_y = y_bus[r*YID_W +: YID_W];
        end
    end

    always_comb begin
        if (is_y_q) begin
            cur_id   = XID_W'(sel_y);
            cur_row  = 3'(idx_q);
            cur_col  = 4'd0;
            cur_skip = SKIP_UNUSED && (sel_y == Y_UNUSED);
        end else begin
            cur_id   = sel_x;
            cur_row  = 3'(idx_q / IDX_W'(NUM_COL));
            cur_col  = 4'(idx_q % IDX_W'(NUM_COL));
            cur_skip = SKIP_UNUSED && (sel_x == X_UNUSED);
        end
    end

    always_comb begin
        nxt_net  = net_q;
        nxt_is_y = is_y_q;
        nxt_idx  = idx_q + IDX_W'(1);
        nxt_end  = 1'b0;
        if (is_y_q) begin
            if (idx_q == IDX_W'(NUM_ROW - 1)) begin
                nxt_is_y = 1'b0;
                nxt_idx  = '0;
            end
        end else if (idx_q == IDX_W'(NUM_PE - 1)) begin
            nxt_is_y = 1'b1;
            nxt_idx  = '0;
            if (net_q == 2'd3) nxt_end = 1'b1;
            else               nxt_net = net_q + 2'd1;
        end
    end

    // The output register refills when empty or when its beat is taken.
    always_comb begin
        state_d  = state_q;
        net_d    = net_q;
        is_y_d   = is_y_q;
        idx_d    = idx_q;
        end_d    = end_q;
        valid_d  = valid_q;
        o_net_d  = o_net_q;
        o_is_y_d = o_is_y_q;
        o_row_d  = o_row_q;
        o_col_d  = o_col_q;
        o_id_d   = o_id_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_SEND;
                    net_d   = 2'd0;
                    is_y_d  = 1'b1;
                    idx_d   = '0;
                    end_d   = 1'b0;
                    valid_d = 1'b0;
                end
            end
            S_SEND: begin
                if (!valid_q || cfg_ready) begin
                    if (end_q) begin
                        state_d = S_DONE;
                        valid_d = 1'b0;
                    end else begin
                        valid_d = !cur_skip;
                        net_d   = nxt_net;
                        is_y_d  = nxt_is_y;
                        idx_d   = nxt_idx;
                        end_d   = nxt_end;
                        if (!cur_skip) begin
                            o_net_d  = net_q;
                            o_is_y_d = is_y_q;
                            o_row_d  = cur_row;
                            o_col_d  = cur_col;
                            o_id_d   = cur_id;
                        end
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            net_q    <= 2'd0;
            is_y_q   <= 1'b0;
            idx_q    <= '0;
            end_q    <= 1'b0;
            valid_q  <= 1'b0;
            o_net_q  <= 2'd0;
            o_is_y_q <= 1'b0;
            o_row_q  <= 3'd0;
            o_col_q  <= 4'd0;
            o_id_q   <= '0;
        end else begin
            state_q  <= state_d;
            net_q    <= net_d;
            is_y_q   <= is_y_d;
            idx_q    <= idx_d;
            end_q    <= end_d;
            valid_q  <= valid_d;
            o_net_q  <= o_net_d;
            o_is_y_q <= o_is_y_d;
            o_row_q  <= o_row_d;
            o_col_q  <= o_col_d;
            o_id_q   <= o_id_d;
        end
    end

    assign cfg_valid = valid_q;
    assign cfg_net   = o_net_q;
    assign cfg_is_y  = o_is_y_q;
    assign cfg_row   = o_row_q;
    assign cfg_col   = o_col_q;
    assign cfg_id    = o_id_q;
    assign busy      = (state_q == S_SEND);
    assign done      = (state_q == S_DONE);

endmodule
